// File: rtl/max_pool.sv
// 2x2 stride-2 signed max-pool over a row-major pixel stream; RENKON_POOL_RELU_EN clamps negative maxima to 0.
// Output registered 1 cycle after a window's bottom-right pixel; no backpressure, consumer must take every out_en.
module max_pool #(
  parameter int DWIDTH    = 16,
  parameter int PSIZE_MAX = 16,
  parameter int PWIDTH    = 5
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     pool_start,
  input  logic [PWIDTH-1:0]        pool_size,
  input  logic                     in_en,
  input  logic signed [DWIDTH-1:0] pixel_in,
  output logic                     out_en,
  output logic signed [DWIDTH-1:0] pixel_out,
  output logic                     pool_done
);

  localparam int CW = PWIDTH + 1;
  localparam int AW = (PSIZE_MAX > 1) ? $clog2(PSIZE_MAX) : 1;

  logic [PWIDTH-1:0]        size_q, size_d;
  logic [CW-1:0]            col_q, col_d, row_q, row_d;
  logic signed [DWIDTH-1:0] hold_q, hold_d;
  logic                     out_en_q, out_en_d;
  logic signed [DWIDTH-1:0] pixel_out_q, pixel_out_d;
  logic                     pool_done_q, pool_done_d;
  logic signed [DWIDTH-1:0] buf_q [PSIZE_MAX];

  logic [PWIDTH-1:0]        size_eff;
  logic [CW-1:0]            col_cur, row_cur, last_idx;
  logic [AW-1:0]            bidx;
  logic                     accept, col_last, row_last, buf_we;
  logic signed [DWIDTH-1:0] buf_rd, m_top, m_bot, pool_val;

  function automatic logic signed [DWIDTH-1:0] smax(input logic signed [DWIDTH-1:0] a,
                                                    input logic signed [DWIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // A pool_start pixel is treated as (0,0) of the new map with the new size.
  assign size_eff = pool_start ? pool_size : size_q;
  assign col_cur  = pool_start ? '0 : col_q;
  assign row_cur  = pool_start ? '0 : row_q;
  assign last_idx = {size_eff, 1'b0} - CW'(1);
  assign accept   = in_en && (size_eff != '0);
  assign col_last = (col_cur == last_idx);
  assign row_last = (row_cur == last_idx);
  assign bidx     = col_cur[AW:1];
  assign buf_rd   = buf_q[bidx];
  assign m_top    = smax(hold_q, pixel_in);
  assign m_bot    = smax(buf_rd, pixel_in);

`ifdef RENKON_POOL_RELU_EN
  assign pool_val = m_top[DWIDTH-1] ? '0 : m_top;
`else
  assign pool_val = m_top;
`endif

  always_comb begin
    size_d      = size_eff;
    col_d       = col_cur;
    row_d       = row_cur;
    hold_d      = hold_q;
    out_en_d    = 1'b0;
    pool_done_d = 1'b0;
    pixel_out_d = pixel_out_q;
    buf_we      = 1'b0;
    if (accept) begin
      col_d = col_last ? '0 : col_cur + CW'(1);
      if (col_last) row_d = row_last ? '0 : row_cur + CW'(1);
      case ({row_cur[0], col_cur[0]})
        2'b00: hold_d = pixel_in;
        2'b01: buf_we = 1'b1;
        2'b10: hold_d = m_bot;
        default: begin
          out_en_d    = 1'b1;
          pixel_out_d = pool_val;
          pool_done_d = row_last && col_last;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      size_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_en_q    <= 1'b0;
      pixel_out_q <= '0;
      pool_done_q <= 1'b0;
    end else begin
      size_q      <= size_d;
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_en_q    <= out_en_d;
      pixel_out_q <= pixel_out_d;
      pool_done_q <= pool_done_d;
    end
  end

  // Half-row partial maxima; contents are don't-care until rewritten by an even row.
  always_ff @(posedge clk) begin
    if (xrst && buf_we) buf_q[bidx] <= m_top;
  end

  assign out_en    = out_en_q;
  assign pixel_out = pixel_out_q;
  assign pool_done = pool_done_q;

endmodule

// File: tb/tb_max_pool.sv
module tb_max_pool;

  logic               clk = 1'b0;
  logic               xrst;
  logic               pool_start;
  logic [4:0]         pool_size;
  logic               in_en;
  logic signed [15:0] pixel_in;
  logic               out_en;
  logic signed [15:0] pixel_out;
  logic               pool_done;

  int checks = 0;
  int errors = 0;

  logic               obs_en, obs_done;
  logic signed [15:0] obs_pix;
  int lv[$];
  int li[$];
  int ld[$];
  int pcnt;

  max_pool #(.DWIDTH(16), .PSIZE_MAX(16), .PWIDTH(5)) dut (
    .clk(clk), .xrst(xrst), .pool_start(pool_start), .pool_size(pool_size),
    .in_en(in_en), .pixel_in(pixel_in), .out_en(out_en), .pixel_out(pixel_out),
    .pool_done(pool_done)
  );

  always #5 clk = ~clk;

  task automatic step(input logic st, input logic [4:0] sz, input logic en, input int px);
    pool_start = st;
    pool_size  = sz;
    in_en      = en;
    pixel_in   = 16'(px);
    @(posedge clk);
    #1;
    obs_en   = out_en;
    obs_pix  = pixel_out;
    obs_done = pool_done;
  endtask

  // Logs outputs against the index of the accepted pixel that produced them (-1 for idle cycles).
  task automatic feed(input logic st, input logic [4:0] sz, input logic en, input int px);
    int idx;
    idx = en ? pcnt : -1;
    step(st, sz, en, px);
    if (en) pcnt++;
    if (obs_en) begin
      lv.push_back(int'(obs_pix));
      li.push_back(idx);
    end
    if (obs_done) ld.push_back(idx);
  endtask

  task automatic clear_log();
    lv.delete(); li.delete(); ld.delete(); pcnt = 0;
  endtask

  task automatic test_reset();
    xrst = 1'b0;
    step(1, 5'd1, 1, 7);
    step(0, 5'd1, 1, 9);
    checks++; if (obs_en !== 1'b0) begin errors++; $display("FAIL reset_out_en got %b want 0", obs_en); end
    checks++; if (obs_pix !== 16'sd0) begin errors++; $display("FAIL reset_pixel_out got %0d want 0", obs_pix); end
    checks++; if (obs_done !== 1'b0) begin errors++; $display("FAIL reset_pool_done got %b want 0", obs_done); end
    xrst = 1'b1;
    step(0, 5'd0, 0, 0);
  endtask

  task automatic test_basic();
    int ev[4];
    ev = '{5, 7, 13, 15};
    clear_log();
    feed(1, 5'd2, 0, 0);
    for (int i = 0; i < 16; i++) feed(0, 5'd0, 1, i);
    feed(0, 5'd0, 0, 0);
    checks++; if (lv.size() != 4) begin errors++; $display("FAIL basic_count got %0d want 4", lv.size()); end
    for (int k = 0; k < 4 && k < lv.size(); k++) begin
      checks++; if (lv[k] !== ev[k]) begin errors++; $display("FAIL basic_val[%0d] got %0d want %0d", k, lv[k], ev[k]); end
      checks++; if (li[k] !== ev[k]) begin errors++; $display("FAIL basic_latency[%0d] after pixel %0d want %0d", k, li[k], ev[k]); end
    end
    checks++; if (ld.size() != 1 || ld[0] !== 15) begin errors++; $display("FAIL basic_done count %0d want 1 at pixel 15", ld.size()); end
  endtask

  task automatic test_negative();
    int exp_v;
`ifdef RENKON_POOL_RELU_EN
    exp_v = 0;
`else
    exp_v = -3;
`endif
    clear_log();
    feed(1, 5'd1, 0, 0);
    feed(0, 5'd0, 1, -9);
    feed(0, 5'd0, 1, -3);
    feed(0, 5'd0, 1, -7);
    feed(0, 5'd0, 1, -5);
    checks++;
    if (lv.size() != 1 || lv[0] !== exp_v || li[0] !== 3) begin
      errors++; $display("FAIL negative_val count %0d first %0d want one %0d", lv.size(), (lv.size() > 0) ? lv[0] : 9999, exp_v);
    end
    checks++; if (ld.size() != 1 || ld[0] !== 3) begin errors++; $display("FAIL negative_done count %0d want 1", ld.size()); end
  endtask

  task automatic test_gap_rearm();
    int ev[8];
    int ei;
    ev = '{5, 7, 13, 15, 105, 107, 113, 115};
    clear_log();
    feed(1, 5'd2, 0, 0);
    for (int i = 0; i < 16; i++) begin
      feed(0, 5'd0, 1, i);
      feed(0, 5'd0, 0, 0);
    end
    for (int i = 100; i < 116; i++) feed(0, 5'd0, 1, i);
    feed(0, 5'd0, 0, 0);
    checks++; if (lv.size() != 8) begin errors++; $display("FAIL gap_count got %0d want 8", lv.size()); end
    for (int k = 0; k < 8 && k < lv.size(); k++) begin
      ei = (ev[k] < 100) ? ev[k] : ev[k] - 100 + 16;
      checks++;
      if (lv[k] !== ev[k] || li[k] !== ei) begin
        errors++; $display("FAIL gap_out[%0d] got %0d at pixel %0d want %0d at pixel %0d", k, lv[k], li[k], ev[k], ei);
      end
    end
    checks++;
    if (ld.size() != 2 || ld[0] !== 15 || ld[1] !== 31) begin
      errors++; $display("FAIL gap_done count %0d want 2 at pixels 15,31", ld.size());
    end
  endtask

  task automatic test_abort();
    clear_log();
    feed(1, 5'd2, 0, 0);
    for (int i = 0; i < 6; i++) feed(0, 5'd0, 1, i);
    feed(1, 5'd1, 1, 1);
    feed(0, 5'd0, 1, 4);
    feed(0, 5'd0, 1, 2);
    feed(0, 5'd0, 1, 3);
    feed(0, 5'd0, 0, 0);
    // Pixel 5 completes the first window of the old map; the partial windows after it yield nothing.
    checks++; if (lv.size() != 2) begin errors++; $display("FAIL abort_count got %0d want 2", lv.size()); end
    checks++;
    if (lv.size() >= 2 && (lv[0] !== 5 || li[0] !== 5 || lv[1] !== 4 || li[1] !== 9)) begin
      errors++; $display("FAIL abort_vals got %0d,%0d want 5,4", lv[0], lv[1]);
    end
    checks++; if (ld.size() != 1 || ld[0] !== 9) begin errors++; $display("FAIL abort_done count %0d want 1 at pixel 9", ld.size()); end
  endtask

  task automatic test_max_size_reset();
    int e, bad, nz;
    clear_log();
    feed(1, 5'd16, 0, 0);
    for (int i = 0; i < 1024; i++) feed(0, 5'd0, 1, i);
    feed(0, 5'd0, 0, 0);
    checks++; if (lv.size() != 256) begin errors++; $display("FAIL max_count got %0d want 256", lv.size()); end
    bad = 0;
    for (int k = 0; k < 256 && k < lv.size(); k++) begin
      e = (2 * (k / 16) + 1) * 32 + 2 * (k % 16) + 1;
      if (lv[k] !== e || li[k] !== e) begin
        bad++;
        if (bad < 4) $display("FAIL max_out[%0d] got %0d at pixel %0d want %0d", k, lv[k], li[k], e);
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL max_vals %0d bad windows want 0", bad); end
    checks++; if (ld.size() != 1 || ld[0] !== 1023) begin errors++; $display("FAIL max_done count %0d want 1 at pixel 1023", ld.size()); end

    clear_log();
    feed(1, 5'd16, 0, 0);
    for (int i = 0; i < 100; i++) feed(0, 5'd0, 1, i);
    xrst = 1'b0;
    step(0, 5'd0, 1, 100);
    checks++;
    if (obs_en !== 1'b0 || obs_pix !== 16'sd0 || obs_done !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got en=%b pix=%0d done=%b want 0,0,0", obs_en, obs_pix, obs_done);
    end
    xrst = 1'b1;
    clear_log();
    nz = 0;
    for (int i = 0; i < 300; i++) begin
      feed(0, 5'd0, 1, 500 + i);
      if (obs_pix !== 16'sd0) nz++;
    end
    checks++; if (lv.size() != 0 || ld.size() != 0) begin errors++; $display("FAIL postreset_out_en got %0d pulses want 0", lv.size()); end
    checks++; if (nz != 0) begin errors++; $display("FAIL postreset_pixel_out %0d nonzero cycles want 0", nz); end
  endtask

  task automatic test_size_zero();
    clear_log();
    feed(1, 5'd0, 0, 0);
    for (int i = 0; i < 8; i++) feed(0, 5'd0, 1, 20 + i);
    feed(0, 5'd0, 0, 0);
    checks++; if (lv.size() != 0) begin errors++; $display("FAIL zero_out_en got %0d pulses want 0", lv.size()); end
    checks++; if (ld.size() != 0) begin errors++; $display("FAIL zero_done got %0d pulses want 0", ld.size()); end
  endtask

  initial begin
    xrst = 1'b0; pool_start = 1'b0; pool_size = '0; in_en = 1'b0; pixel_in = '0;
    pcnt = 0;
    test_reset();
    test_basic();
    test_negative();
    test_gap_rearm();
    test_abort();
    test_max_size_reset();
    test_size_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
